// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM transmitter: FSM encoding, default
// configuration values and the high-time clamp.
package pwm_pkg;

  localparam int CNT_WIDTH_DEF      = 32;
  localparam int DEFAULT_PERIOD_DEF = 1000;
  localparam int DEFAULT_HIGH_DEF   = 500;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

  // Effective high time: a high time longer than the period saturates to it.
  function automatic logic [CNT_WIDTH_DEF-1:0] clamp_high(
    input logic [CNT_WIDTH_DEF-1:0] high,
    input logic [CNT_WIDTH_DEF-1:0] period
  );
    return (high > period) ? period : high;
  endfunction

endpackage

// File: rtl/pwm_gen_if.sv
// Configuration channel of the PWM transmitter (valid/ready handshake
// carrying a requested period and high time).
interface pwm_gen_if
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic [CNT_WIDTH-1:0] cfg_high;

  modport master (output cfg_valid, output cfg_period, output cfg_high, input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_period, input  cfg_high, output cfg_ready);
endinterface

// File: rtl/pwm_cfg_shadow.sv
// Double-buffered PWM configuration: one pending slot filled through the
// valid/ready handshake, and the active config that only changes when the
// FSM pulses `apply` on a period boundary. The high time is clamped to the
// period when it enters the pending slot, so everything downstream sees
// effective values.
module pwm_cfg_shadow
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_DEF,
  parameter int DEFAULT_HIGH   = DEFAULT_HIGH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 apply,
  pwm_gen_if.slave             cfg,
  output logic [CNT_WIDTH-1:0] act_period,
  output logic [CNT_WIDTH-1:0] act_high,
  output logic [CNT_WIDTH-1:0] nxt_period,
  output logic [CNT_WIDTH-1:0] nxt_high,
  output logic                 pend_zero
);

  localparam logic [CNT_WIDTH-1:0] RST_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [CNT_WIDTH-1:0] RST_HIGH   = clamp_high(CNT_WIDTH'(DEFAULT_HIGH), RST_PERIOD);

  logic                 pend_full;
  logic [CNT_WIDTH-1:0] pend_period;
  logic [CNT_WIDTH-1:0] pend_high;
  logic                 xfer;

  assign cfg.cfg_ready = !pend_full;
  assign xfer          = cfg.cfg_valid && !pend_full;

  // Config the FSM would run if a period started now.
  assign nxt_period = pend_full ? pend_period : act_period;
  assign nxt_high   = pend_full ? pend_high   : act_high;
  assign pend_zero  = pend_full && (pend_period == '0);

  // Pending-slot occupancy: filled by a transfer, emptied when applied.
  always_ff @(posedge clk) begin
    if (rst)        pend_full <= 1'b0;
    else if (xfer)  pend_full <= 1'b1;
    else if (apply) pend_full <= 1'b0;
  end

  // Pending payload; only meaningful while pend_full is set.
  always_ff @(posedge clk) begin
    if (xfer) begin
      pend_period <= cfg.cfg_period;
      pend_high   <= clamp_high(cfg.cfg_high, cfg.cfg_period);
    end
  end

  // Active config: defaults out of reset, replaced only on an apply strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_period <= RST_PERIOD;
      act_high   <= RST_HIGH;
    end else if (apply && pend_full) begin
      act_period <= pend_period;
      act_high   <= pend_high;
    end
  end

endmodule

// File: rtl/pwm_gen.sv
// PWM transmitter top. An IDLE/HIGH/LOW FSM with a single down-counter
// emits exact P-cycle periods with H_eff high cycles; new configurations
// are taken from pwm_cfg_shadow only at period starts.
// Optional feature macro: PWM_GEN_COMPL_EN (dead-time guarded
// complementary output on pwm_out_n; tied low when undefined).
module pwm_gen
  import pwm_pkg::*;
#(
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF,
  parameter int DEFAULT_PERIOD = DEFAULT_PERIOD_DEF,
  parameter int DEFAULT_HIGH   = DEFAULT_HIGH_DEF,
  parameter int DEADTIME       = 4
) (
  input  logic                 pwd_clk,
  input  logic                 sysreset,
  input  logic                 enable,
  pwm_gen_if.slave             cfg,
  output logic                 pwm_out,
  output logic                 pwm_out_n,
  output logic                 period_start,
  output logic [CNT_WIDTH-1:0] high_count_out,
  output logic [CNT_WIDTH-1:0] low_count_out,
  output logic [31:0]          period_count
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  pwm_state_e           state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 start, apply, period_end;

  logic [CNT_WIDTH-1:0] act_period, act_high, act_low;
  logic [CNT_WIDTH-1:0] nxt_period, nxt_high, nxt_low;
  logic                 pend_zero;

  pwm_cfg_shadow #(
    .CNT_WIDTH      (CNT_WIDTH),
    .DEFAULT_PERIOD (DEFAULT_PERIOD),
    .DEFAULT_HIGH   (DEFAULT_HIGH)
  ) u_shadow (
    .clk        (pwd_clk),
    .rst        (sysreset),
    .apply      (apply),
    .cfg        (cfg),
    .act_period (act_period),
    .act_high   (act_high),
    .nxt_period (nxt_period),
    .nxt_high   (nxt_high),
    .pend_zero  (pend_zero)
  );

  assign act_low        = act_period - act_high;
  assign nxt_low        = nxt_period - nxt_high;
  assign high_count_out = act_high;
  assign low_count_out  = act_low;

  // Next state: count down the current phase; at a boundary either start
  // the next period (applying any pending config) or fall back to IDLE.
  // A pending P=0 config is applied even without a start so it can park
  // the FSM in IDLE instead of blocking the pending slot forever.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    start      = 1'b0;
    apply      = 1'b0;
    period_end = 1'b0;
    case (state)
      ST_HIGH: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - ONE;
        end else if (act_low != '0) begin
          state_nxt = ST_LOW;
          cnt_nxt   = act_low - ONE;
        end else begin
          period_end = 1'b1;
        end
      end
      ST_LOW: begin
        if (cnt != '0) cnt_nxt = cnt - ONE;
        else           period_end = 1'b1;
      end
      default: ;
    endcase
    if ((state == ST_IDLE) || period_end) begin
      state_nxt = ST_IDLE;
      if (enable && (nxt_period != '0)) begin
        start = 1'b1;
        apply = 1'b1;
        if (nxt_high != '0) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = nxt_high - ONE;
        end else begin
          state_nxt = ST_LOW;
          cnt_nxt   = nxt_low - ONE;
        end
      end else if (pend_zero) begin
        apply = 1'b1;
      end
    end
  end

  // FSM, phase counter and registered outputs.
  always_ff @(posedge pwd_clk) begin
    if (sysreset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      period_count <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pwm_out      <= (state_nxt == ST_HIGH);
      period_start <= start;
      period_count <= period_count + {31'b0, start};
    end
  end

`ifdef PWM_GEN_COMPL_EN
  logic [CNT_WIDTH-1:0] low_sel;
  logic [CNT_WIDTH:0]   cnt_ext, low_ext, dt_ext;
  logic                 compl_on;

  // LOW-phase cycles are numbered by the remaining count; the complement is
  // on only when at least DEADTIME cycles separate it from both edges.
  always_comb begin
    low_sel  = start ? nxt_low : act_low;
    cnt_ext  = {1'b0, cnt_nxt};
    low_ext  = {1'b0, low_sel};
    dt_ext   = (CNT_WIDTH+1)'(DEADTIME);
    compl_on = (state_nxt == ST_LOW) && (cnt_ext >= dt_ext) && ((cnt_ext + dt_ext) < low_ext);
  end

  // Registered complementary output.
  always_ff @(posedge pwd_clk) begin
    if (sysreset) pwm_out_n <= 1'b0;
    else          pwm_out_n <= compl_on;
  end
`else
  // Constant 0; DEADTIME only matters when the complement is built.
  assign pwm_out_n = (DEADTIME < 0);
`endif

endmodule

// File: tb/tb_pwm_gen.sv
// Self-checking bench for pwm_gen: directed scenarios followed by random
// configs/enable/reset, compared every cycle against a period-position
// reference model.
module tb_pwm_gen;

  localparam int DT = 4;

  logic        pwd_clk = 1'b0;
  logic        sysreset;
  logic        enable;
  logic        pwm_out, pwm_out_n, period_start;
  logic [31:0] high_count_out, low_count_out, period_count;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_gen_if #(.CNT_WIDTH(32)) bus ();

  pwm_gen #(
    .CNT_WIDTH      (32),
    .DEFAULT_PERIOD (1000),
    .DEFAULT_HIGH   (500),
    .DEADTIME       (DT)
  ) dut (
    .pwd_clk        (pwd_clk),
    .sysreset       (sysreset),
    .enable         (enable),
    .cfg            (bus),
    .pwm_out        (pwm_out),
    .pwm_out_n      (pwm_out_n),
    .period_start   (period_start),
    .high_count_out (high_count_out),
    .low_count_out  (low_count_out),
    .period_count   (period_count)
  );

  always #5 pwd_clk = ~pwd_clk;

  // Reference model: position inside the running period plus config slots.
  bit          m_run, m_ps, m_pend_full;
  logic [31:0] m_pos, m_P, m_H, m_pend_P, m_pend_H, m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] np, nh;
    bit xfer, boundary;
    if (sysreset) begin
      m_run = 0; m_ps = 0; m_pos = 0; m_P = 1000; m_H = 500;
      m_pend_full = 0; m_cnt = 0;
      return;
    end
    xfer     = bus.cfg_valid && !m_pend_full;
    boundary = !m_run || (m_pos == m_P - 1);
    m_ps     = 0;
    if (boundary) begin
      np = m_pend_full ? m_pend_P : m_P;
      nh = m_pend_full ? ((m_pend_H > m_pend_P) ? m_pend_P : m_pend_H) : m_H;
      if (enable && np != 0) begin
        m_P = np; m_H = nh; m_pend_full = 0;
        m_run = 1; m_pos = 0; m_cnt = m_cnt + 1; m_ps = 1;
      end else begin
        m_run = 0;
        if (m_pend_full && m_pend_P == 0) begin
          m_P = 0; m_H = 0; m_pend_full = 0;
        end
      end
    end else begin
      m_pos = m_pos + 1;
    end
    if (xfer) begin
      m_pend_full = 1; m_pend_P = bus.cfg_period; m_pend_H = bus.cfg_high;
    end
  endtask

  task automatic compare_all();
    bit e_n;
`ifdef PWM_GEN_COMPL_EN
    e_n = m_run && (m_pos >= m_H + DT) && (m_pos + DT < m_P);
`else
    e_n = 1'b0;
`endif
    chk("pwm_out",      {31'b0, pwm_out},       {31'b0, m_run && (m_pos < m_H)});
    chk("pwm_out_n",    {31'b0, pwm_out_n},     {31'b0, e_n});
    chk("overlap",      {31'b0, pwm_out & pwm_out_n}, 32'd0);
    chk("period_start", {31'b0, period_start},  {31'b0, m_ps});
    chk("period_count", period_count,           m_cnt);
    chk("high_count",   high_count_out,         m_H);
    chk("low_count",    low_count_out,          m_P - m_H);
    chk("cfg_ready",    {31'b0, bus.cfg_ready}, {31'b0, !m_pend_full});
  endtask

  task automatic tick();
    @(posedge pwd_clk);
    model_step();
    @(negedge pwd_clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_cfg(input logic [31:0] p, input logic [31:0] h);
    int n = 0;
    bus.cfg_period = p; bus.cfg_high = h; bus.cfg_valid = 1'b1;
    while (!bus.cfg_ready && n < 3000) begin tick(); n++; end
    if (!bus.cfg_ready) chk("cfg_ready_timeout", {31'b0, bus.cfg_ready}, 32'd1);
    tick();
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_start(input int max);
    int n = 0;
    do begin tick(); n++; end while (!period_start && n < max);
    if (!period_start) chk("start_timeout", {31'b0, period_start}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    sysreset = 1'b1; enable = 1'b0;
    bus.cfg_valid = 1'b0; bus.cfg_period = '0; bus.cfg_high = '0;
    run(3);
    chk("rst_pwm",   {31'b0, pwm_out}, 32'd0);
    chk("rst_ps",    {31'b0, period_start}, 32'd0);
    chk("rst_cnt",   period_count, 32'd0);
    chk("rst_ready", {31'b0, bus.cfg_ready}, 32'd1);
    chk("rst_hi",    high_count_out, 32'd500);
    chk("rst_lo",    low_count_out, 32'd500);

    // Defaults, three full periods.
    sysreset = 1'b0; enable = 1'b1;
    tick();
    chk("first_start", {31'b0, period_start}, 32'd1);
    chk("first_high",  {31'b0, pwm_out}, 32'd1);
    run(2999);
    chk("cnt_after3",  period_count, 32'd3);

    // Mid-period switch to P=10,H=3.
    run(50);
    send_cfg(32'd10, 32'd3);
    chk("ready_low_pending", {31'b0, bus.cfg_ready}, 32'd0);
    chk("hi_before_switch",  high_count_out, 32'd500);
    wait_start(1100);
    chk("hi_after_switch", high_count_out, 32'd3);
    chk("lo_after_switch", low_count_out, 32'd7);
    run(30);

    // Clamp and degenerate configs.
    send_cfg(32'd8, 32'd20);  run(30);
    send_cfg(32'd8, 32'd0);   run(30);
    send_cfg(32'd0, 32'd5);   run(30);
    chk("p0_idle_pwm", {31'b0, pwm_out}, 32'd0);

    // Back-to-back configs, also exercising the complementary output.
    send_cfg(32'd20, 32'd5); run(5);
    send_cfg(32'd12, 32'd5);
    send_cfg(32'd10, 32'd3);
    run(40);

    // Enable dropped two cycles into a period.
    wait_start(40);
    tick();
    enable = 1'b0;
    run(20);
    chk("idle_after_drop", {31'b0, pwm_out}, 32'd0);

    // Reset in the middle of HIGH.
    enable = 1'b1;
    wait_start(20);
    tick();
    sysreset = 1'b1;
    tick();
    chk("rstmid_pwm", {31'b0, pwm_out}, 32'd0);
    chk("rstmid_cnt", period_count, 32'd0);
    chk("rstmid_hi",  high_count_out, 32'd500);
    chk("rstmid_lo",  low_count_out, 32'd500);
    sysreset = 1'b0;

    // Random configs, enable toggles and occasional resets.
    for (int i = 0; i < 6000; i++) begin
      acc = bus.cfg_valid && bus.cfg_ready;
      tick();
      if (acc) bus.cfg_valid = 1'b0;
      if (!bus.cfg_valid && $urandom_range(0, 9) == 0) begin
        bus.cfg_period = ($urandom_range(0, 19) == 0) ? 32'd0 : 32'($urandom_range(1, 40));
        bus.cfg_high   = 32'($urandom_range(0, 45));
        bus.cfg_valid  = 1'b1;
      end
      if ($urandom_range(0, 49) == 0) enable = ~enable;
      sysreset = ($urandom_range(0, 1999) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- Programmable PWM transmitter: produces `pwm_out` with a configurable period and high time.
- Forms the transmit end of the PWM link whose receive end measures up/down counts and averages.
- Configuration arrives from the MicroBlaze GPIO bridge over a valid/ready handshake.
- A new configuration is double-buffered and applied only on period boundaries, so no runt or glitched pulses are ever emitted.

Parameters:
- CNT_WIDTH, 32: width of period/high counters and config fields.
- DEFAULT_PERIOD, 1000: active period (cycles) loaded at reset.
- DEFAULT_HIGH, 500: active high time (cycles) loaded at reset.
- DEADTIME, 4: guard cycles for the complementary output (only used with PWM_GEN_COMPL_EN).

Ports:
- pwd_clk  in  1  system clock; all logic on rising edge.
- sysreset  in  1  synchronous, active-high reset.
- enable  in  1  run request; level-sensitive.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  pending slot empty; transfer when cfg_valid && cfg_ready.
- cfg_period  in  CNT_WIDTH  requested period P in cycles.
- cfg_high  in  CNT_WIDTH  requested high time H in cycles.
- pwm_out  out  1  registered PWM output.
- pwm_out_n  out  1  complementary output (see Optional Feature).
- period_start  out  1  one-cycle pulse on the first cycle of each period.
- high_count_out  out  CNT_WIDTH  effective high time of the active config.
- low_count_out  out  CNT_WIDTH  effective low time of the active config (P - H_eff).
- period_count  out  32  number of periods started; wraps 2^32-1 -> 0.

Behaviour:
- Reset state (sysreset sampled high):
  - Outputs: pwm_out=0, pwm_out_n=0, period_start=0, period_count=0.
  - FSM in IDLE; pending slot empty, so cfg_ready=1.
  - Active config = DEFAULT_PERIOD/DEFAULT_HIGH; high_count_out/low_count_out reflect it.
  - Reset wins over all other inputs. Reset asserted mid-period aborts the period immediately, with no completion.
- Effective values:
  - H_eff = min(H, P).
  - P=0: config accepted and applied, but the FSM treats it as "no output". It stays or returns to IDLE with pwm_out=0 and emits no period_start, even if enable=1.
- FSM states: IDLE, HIGH, LOW. One down-counter `cnt`.
  - IDLE -> period start when enable=1 and active P>0. On the next edge, apply any pending config, assert period_start, load cnt, and enter HIGH (if H_eff>0) or LOW (if H_eff=0).
  - HIGH: pwm_out=1 for exactly H_eff cycles, then LOW.
  - LOW: pwm_out=0 for exactly P-H_eff cycles. If H_eff=P, LOW is skipped.
  - End of period: if enable=1, start the next period back-to-back with no gap cycle; otherwise go to IDLE.
  - Deasserting enable mid-period never truncates; the current period completes.
- Latency: enable sampled high in cycle t gives period_start=1 and pwm_out valid in cycle t+1. The resulting waveform has an exact period of P cycles.
- Config handshake:
  - A transfer loads the pending slot and drops cfg_ready the next cycle.
  - At each period start the pending config becomes active, the slot empties, and cfg_ready rises the next cycle.
  - A config accepted in the same cycle as a period-start edge applies at the following boundary, not the current one.
  - In IDLE, a pending config applies at the next period start. high_count_out/low_count_out update only when a config becomes active.
- period_count increments in the cycle period_start is asserted.

Optional Feature:
- Macro: PWM_GEN_COMPL_EN.
- Defined:
  - pwm_out_n is a registered, break-before-make complement. It is high only in LOW-phase cycles at least DEADTIME cycles after the falling edge of pwm_out and at least DEADTIME cycles before the next period start.
  - If P-H_eff <= 2*DEADTIME, pwm_out_n stays 0 for that period.
  - pwm_out_n is 0 in IDLE, in HIGH, and in reset.
  - pwm_out and pwm_out_n are never both 1.
- Undefined: pwm_out_n tied to 0; no extra logic.

Decomposition:
- Package pwm_pkg:
  - FSM state encoding (IDLE/HIGH/LOW).
  - Default CNT_WIDTH, DEFAULT_PERIOD, DEFAULT_HIGH.
  - Clamp helper for H_eff.
- One sub-module, pwm_cfg_shadow: the pending/active config registers and the valid/ready handshake, with an `apply` strobe input driven by the FSM at period start.

Test Plan:
- Reset, then enable=1 with defaults -> first period_start one cycle later; pwm_out 500 high / 500 low repeating; period_count=3 after 3 periods.
- Config P=10,H=3 accepted mid-period (default config running) -> current 1000-cycle period completes unchanged, then 3 high/7 low; high_count_out=3, low_count_out=7 after the switch.
- Clamp and edge cases:
  - P=8,H=20 -> pwm_out constantly 1, period_start every 8 cycles.
  - P=8,H=0 -> constantly 0, period_start every 8 cycles.
  - P=0 -> IDLE, pwm_out=0, no period_start.
- Two back-to-back configs:
  - First accepted; cfg_ready=0 until the next period start.
  - Second held off by cfg_ready=0, then accepted, and applies one period after the first.
- Enable dropped 2 cycles into a P=10,H=3 period -> period finishes 10 cycles total, then IDLE, pwm_out=0.
- Reset asserted mid-HIGH -> pwm_out=0 next cycle, period_count=0, active config back to 1000/500.
- With PWM_GEN_COMPL_EN, DEADTIME=4:
  - P=20,H=5 -> pwm_out_n high for 7 cycles per period, never overlapping pwm_out.
  - P=12,H=5 -> pwm_out_n stays 0.
